// File: rtl/multicycle_stage_sequencer.sv
// Multicycle stage sequencer. It steps the datapath through NUM_STAGES stages,
// stalls the memory stage until RAM1_MFC arrives or a timeout expires, stops at
// instruction boundaries, and keeps instruction and active-cycle counters.
// Legal parameters: 3 <= NUM_STAGES <= 6, 2 <= MEM_STAGE < NUM_STAGES,
// 1 <= MFC_TIMEOUT <= 255, and 2**STAGE_W - 1 > NUM_STAGES.
module multicycle_stage_sequencer #(
  parameter int unsigned NUM_STAGES  = 5,
  parameter int unsigned MEM_STAGE   = 4,
  parameter int unsigned MFC_TIMEOUT = 15,
  parameter int unsigned STAGE_W     = 3
) (
  input  logic                  Clock,
  input  logic                  Reset_L,
  input  logic                  Run,
  input  logic                  Halt_Req,
  input  logic                  Mem_Access,
  input  logic                  Mem_Write,
  input  logic                  RAM1_MFC,
  output logic [STAGE_W-1:0]    Stage,
  output logic [NUM_STAGES-1:0] Stage_OneHot,
  output logic                  IR_Enable,
  output logic                  PC_Enable,
  output logic                  RAM1_Read,
  output logic                  RAM1_Write_L,
  output logic                  Stall,
  output logic                  Mem_Timeout,
  output logic [31:0]           Instr_Count,
  output logic [31:0]           Cycle_Count
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned WAIT_W = 8;

  localparam logic [STAGE_W-1:0] STAGE_IDLE  = '0;
  localparam logic [STAGE_W-1:0] STAGE_HALT  = '1;
  localparam logic [STAGE_W-1:0] STAGE_FIRST = STAGE_W'(1);
  localparam logic [STAGE_W-1:0] STAGE_LAST  = STAGE_W'(NUM_STAGES);
  localparam logic [STAGE_W-1:0] STAGE_MEM   = STAGE_W'(MEM_STAGE);
  localparam logic [WAIT_W-1:0]  WAIT_LIMIT  = WAIT_W'(MFC_TIMEOUT - 1);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_RUN    = 2'd1,
    MODE_HALTED = 2'd2
  } mode_e;

  mode_e                  mode_q, mode_d;
  logic [STAGE_W-1:0]     stage_q, stage_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       instr_q, instr_d;
  logic [CNT_W-1:0]       cycle_q, cycle_d;
  logic [NUM_STAGES-1:0]  onehot_q, onehot_d;
  logic                   stage1_q, stage1_d;
  logic                   read_q, read_d;
  logic                   write_l_q, write_l_d;
  logic                   stall_q, stall_d;
  logic                   in_mem_d;

  // Next-state: stage sequencing, MFC wait/timeout and counters
  always_comb begin
    mode_d    = mode_q;
    stage_d   = stage_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    instr_d   = instr_q;
    cycle_d   = cycle_q;
    unique case (mode_q)
      MODE_IDLE: begin
        if (Run && !Halt_Req) begin
          mode_d  = MODE_RUN;
          stage_d = STAGE_FIRST;
        end
      end
      MODE_RUN: begin
        if (cycle_q != '1) cycle_d = cycle_q + CNT_W'(1);
        if (stage_q == STAGE_MEM && Mem_Access && !RAM1_MFC) begin
          if (wait_q == WAIT_LIMIT) begin
            mode_d    = MODE_HALTED;
            stage_d   = STAGE_HALT;
            timeout_d = 1'b1;
            wait_d    = '0;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end else if (stage_q == STAGE_LAST) begin
          instr_d = instr_q + CNT_W'(1);
          wait_d  = '0;
          if (Halt_Req || !Run) begin
            mode_d  = MODE_IDLE;
            stage_d = STAGE_IDLE;
          end else begin
            stage_d = STAGE_FIRST;
          end
        end else begin
          stage_d = stage_q + STAGE_W'(1);
          wait_d  = '0;
        end
      end
      default: begin
        mode_d  = MODE_HALTED;
        stage_d = STAGE_HALT;
      end
    endcase
  end

  // Output decode from the next state so registered outputs align with Stage
  always_comb begin
    onehot_d  = '0;
    in_mem_d  = (mode_d == MODE_RUN) && (stage_d == STAGE_MEM);
    stage1_d  = (mode_d == MODE_RUN) && (stage_d == STAGE_FIRST);
    read_d    = in_mem_d && Mem_Access && !Mem_Write;
    write_l_d = !(in_mem_d && Mem_Access && Mem_Write);
    stall_d   = in_mem_d && (mode_q == MODE_RUN) && (stage_q == STAGE_MEM);
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      onehot_d[k] = (mode_d == MODE_RUN) && (stage_d == STAGE_W'(k + 1));
    end
  end

  // State and registered outputs
  always_ff @(posedge Clock or negedge Reset_L) begin
    if (!Reset_L) begin
      mode_q    <= MODE_IDLE;
      stage_q   <= STAGE_IDLE;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      instr_q   <= '0;
      cycle_q   <= '0;
      onehot_q  <= '0;
      stage1_q  <= 1'b0;
      read_q    <= 1'b0;
      write_l_q <= 1'b1;
      stall_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      stage_q   <= stage_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      instr_q   <= instr_d;
      cycle_q   <= cycle_d;
      onehot_q  <= onehot_d;
      stage1_q  <= stage1_d;
      read_q    <= read_d;
      write_l_q <= write_l_d;
      stall_q   <= stall_d;
    end
  end

  assign Stage        = stage_q;
  assign Stage_OneHot = onehot_q;
  assign IR_Enable    = stage1_q;
  assign PC_Enable    = stage1_q;
  assign RAM1_Read    = read_q;
  assign RAM1_Write_L = write_l_q;
  assign Stall        = stall_q;
  assign Mem_Timeout  = timeout_q;
  assign Instr_Count  = instr_q;
  assign Cycle_Count  = cycle_q;

endmodule

// File: doc/multicycle_stage_sequencer.md
Name: multicycle_stage_sequencer

Overview:
Parametrised successor to the fixed 5-stage stage counter inside the control signal generator. It sequences the multicycle datapath through NUM_STAGES stages and stalls the memory stage until RAM1_MFC arrives, with a timeout. It also supports run/halt at instruction boundaries and keeps performance counters. It sits between the decode logic, which supplies Mem_Access/Mem_Write, and the per-stage register enables and RAM control.

Parameters:
NUM_STAGES, 5, number of pipeline-style stages per instruction (3..6)
MEM_STAGE, 4, stage in which memory access happens (2 <= MEM_STAGE < NUM_STAGES)
MFC_TIMEOUT, 15, maximum wait cycles for RAM1_MFC before fault (1..255)
STAGE_W, 3, width of Stage code; must satisfy 2^STAGE_W - 1 > NUM_STAGES

Ports:
Clock  input  1  system clock, rising edge
Reset_L  input  1  asynchronous active-low reset
Run  input  1  1 = execute instructions; sampled at IDLE and at last stage
Halt_Req  input  1  stop at next instruction boundary
Mem_Access  input  1  current instruction accesses RAM in MEM_STAGE
Mem_Write  input  1  with Mem_Access: 1 = store, 0 = load
RAM1_MFC  input  1  memory function complete
Stage  output  STAGE_W  0 = IDLE, 1..NUM_STAGES = active stage, all-ones = HALTED
Stage_OneHot  output  NUM_STAGES  bit k-1 set in stage k, 0 in IDLE/HALTED
IR_Enable  output  1  high in stage 1
PC_Enable  output  1  high in stage 1
RAM1_Read  output  1  load request
RAM1_Write_L  output  1  store request, active low
Stall  output  1  waiting on MFC
Mem_Timeout  output  1  sticky fault flag
Instr_Count  output  32  completed instructions
Cycle_Count  output  32  active cycles

Behaviour:
- Reset (Reset_L=0, asynchronous): Stage=0, all one-hot/enable/request outputs 0, RAM1_Write_L=1, Stall=0, Mem_Timeout=0, both counters 0. Reset mid-wait aborts the access immediately.
- All outputs are Moore-decoded from registered state and valid in the same cycle as Stage.
- IDLE: go to stage 1 on an edge with Run=1 and Halt_Req=0; otherwise stay.
- Stage k, where k != MEM_STAGE and k < NUM_STAGES: go to k+1 unconditionally.
- MEM_STAGE with Mem_Access=0: advance after 1 cycle.
- MEM_STAGE with Mem_Access=1:
  - Assert RAM1_Read=1 if Mem_Write=0, or RAM1_Write_L=0 if Mem_Write=1. Never both.
  - Hold the request every cycle in the stage.
  - RAM1_MFC=1 at an edge: advance; the request drops with the stage.
  - RAM1_MFC=1 on the first cycle: zero stall.
  - Stall=1 on every cycle after the first that is spent in MEM_STAGE.
  - Wait counter counts edges with MFC=0. When it reaches MFC_TIMEOUT: set Mem_Timeout, go to HALTED, drop requests.
  - Mem_Access and Mem_Write are sampled every cycle; decode holds them stable.
- Last stage (NUM_STAGES): Instr_Count += 1, wrapping modulo 2^32.
  - Halt_Req=1 or Run=0: go to IDLE.
  - Otherwise: go to stage 1.
  - Run or Halt changes mid-instruction have no effect until this boundary.
- HALTED: absorbing. Outputs as in IDLE except Mem_Timeout=1. Leave only by reset.
- Cycle_Count increments every edge where Stage is neither IDLE nor HALTED, including stall cycles; saturates at 0xFFFFFFFF.

Test Plan:
- NUM_STAGES=5, Run=1 from reset, Mem_Access=0 -> Stage 1,2,3,4,5,1...; IR_Enable/PC_Enable high only in stage 1; Instr_Count=2, Cycle_Count=10 after 10 active cycles.
- Load: Mem_Access=1, Mem_Write=0, RAM1_MFC rises on the 4th cycle of stage 4 -> RAM1_Read=1 for 4 cycles; Stall=1 for cycles 2-4 (3 cycles); then stage 5; instruction takes 8 cycles.
- Store with RAM1_MFC already high -> RAM1_Write_L=0 for exactly 1 cycle, Stall never asserted, RAM1_Read stays 0.
- MFC_TIMEOUT=15, load, RAM1_MFC held 0 -> after 15 edges in stage 4, Stage=7, Mem_Timeout=1, requests released; Run toggling has no effect until Reset_L=0.
- Halt_Req pulsed in stage 2 and cleared in stage 3 -> instruction completes; Halt_Req is not latched, so the machine returns to stage 1. Halt_Req held through stage 5 -> IDLE, Instr_Count+1.
- Reset_L=0 asynchronously mid-stall -> all outputs at reset values before the next edge; RAM1_Write_L=1; counters=0.
- MEM_STAGE=2, NUM_STAGES=3 -> stall occurs in stage 2.
- NUM_STAGES=6 -> Stage_OneHot is 6 bits wide and wraps from stage 6 to stage 1.
